issue_scheduler: RTL

Sequences instructions out of the ESM instruction buffer: accepts decoded instructions into a circular buffer of `bs` slots, tracks per-slot register-use masks, and issues the oldest slot with no register hazard against any older live slot. It sits between decode and the execution units; execution returns the slot index on completion, which frees the slot for in-order reclamation.

---
 rtl/esm_pkg.sv | 33 +++
 rtl/age_priority_picker.sv | 33 +++
 rtl/issue_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/esm_pkg.sv
// Shared types and sizing for the ESM issue scheduler: slot states, instruction
// fields and the register one-hot helper used to build hazard masks.
package esm_pkg;

    localparam int BS     = 32;
    localparam int REGNUM = 16;
    localparam int IDX_W  = $clog2(BS);
    localparam int REG_W  = $clog2(REGNUM);
    localparam int CNT_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_WAIT   = 2'd1,
        SLOT_ISSUED = 2'd2
    } slot_state_e;

    typedef logic [REGNUM-1:0] reg_mask_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } inst_fields_t;

    // x0 is hard-wired zero, so it never contributes to a hazard.
    function automatic reg_mask_t reg_onehot(input logic [REG_W-1:0] idx);
        reg_mask_t m;
        m = '0;
        if (idx != '0) m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/age_priority_picker.sv
// Rotating priority encoder: returns the request closest to head (the oldest
// slot in the circular buffer) together with a valid flag.
module age_priority_picker
    import esm_pkg::*;
(
    input  logic [BS-1:0]    req,
    input  logic [IDX_W-1:0] head,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    logic [BS-1:0]    rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rot   = '0;
        valid = 1'b0;
        off   = '0;
        for (int k = 0; k < BS; k++) begin
            rot[k] = req[head + IDX_W'(k)];
        end
        // Scanning downward leaves the smallest age offset in off.
        for (int k = BS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                off   = IDX_W'(k);
            end
        end
        index = head + off;
    end

endmodule

// File: rtl/issue_scheduler.sv
// In-order-reclaim circular instruction buffer that issues the oldest slot free
// of RAW/WAR/WAW hazards against every older live slot.
module issue_scheduler
    import esm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REG_W-1:0] in_rd,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [IDX_W-1:0] issue_index,
    output logic [REG_W-1:0] issue_rd,
    output logic [REG_W-1:0] issue_rs1,
    output logic [REG_W-1:0] issue_rs2,
    input  logic             done_valid,
    input  logic [IDX_W-1:0] done_index,
    output logic [CNT_W-1:0] count
);

    slot_state_e  state    [BS];
    reg_mask_t    rd_mask  [BS];
    reg_mask_t    rs_mask  [BS];
    inst_fields_t fields   [BS];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic             held;
    logic [IDX_W-1:0] held_idx;

    logic [IDX_W-1:0] age      [BS];
    logic [BS-1:0]    live;
    logic [BS-1:0]    older    [BS];
    logic [BS-1:0]    conflict [BS];
    logic [BS-1:0]    req;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] offer_idx;
    logic             enq;
    logic             reclaim;
    logic             issue_fire;

    // Hazard matrix: older[i][j] marks live slot j as older than slot i.
    always_comb begin
        live = '0;
        req  = '0;
        for (int i = 0; i < BS; i++) begin
            age[i]  = IDX_W'(i) - head;
            live[i] = (state[i] != SLOT_FREE);
        end
        for (int i = 0; i < BS; i++) begin
            older[i]    = '0;
            conflict[i] = '0;
            for (int j = 0; j < BS; j++) begin
                older[i][j]    = live[j] && (age[j] < age[i]);
                conflict[i][j] = (|(rs_mask[i] & rd_mask[j]))
                               | (|(rd_mask[i] & rs_mask[j]))
                               | (|(rd_mask[i] & rd_mask[j]));
            end
            req[i] = (state[i] == SLOT_WAIT) && ((older[i] & conflict[i]) == '0);
        end
    end

    age_priority_picker u_picker (
        .req   (req),
        .head  (head),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // A pending offer is pinned until accepted, so the picker cannot re-select.
    assign offer_idx   = held ? held_idx : pick_idx;
    assign issue_valid = held | pick_valid;
    assign issue_index = issue_valid ? offer_idx : '0;
    assign issue_rd    = issue_valid ? fields[offer_idx].rd  : '0;
    assign issue_rs1   = issue_valid ? fields[offer_idx].rs1 : '0;
    assign issue_rs2   = issue_valid ? fields[offer_idx].rs2 : '0;

    assign in_ready   = (count != CNT_W'(BS));
    assign enq        = in_valid && in_ready;
    assign issue_fire = issue_valid && issue_ready;
    assign reclaim    = (state[head] == SLOT_FREE) && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the slot array is reset on purpose: reset must drop every in-flight slot at once.
            for (int i = 0; i < BS; i++) begin
                state[i]   <= SLOT_FREE;
                rd_mask[i] <= '0;
                rs_mask[i] <= '0;
                fields[i]  <= '0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            held     <= 1'b0;
            held_idx <= '0;
        end else begin
            // NOTE: all state updates are non-blocking so every term sees start-of-cycle values.
            if (done_valid && state[done_index] == SLOT_ISSUED) begin
                state[done_index] <= SLOT_FREE;
            end
            if (issue_fire) begin
                state[offer_idx] <= SLOT_ISSUED;
            end
            if (enq) begin
                state[tail]   <= SLOT_WAIT;
                rd_mask[tail] <= reg_onehot(in_rd);
                rs_mask[tail] <= reg_onehot(in_rs1) | reg_onehot(in_rs2);
                fields[tail]  <= '{rd: in_rd, rs1: in_rs1, rs2: in_rs2};
                tail          <= tail + 1'b1;
            end
            if (reclaim) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(enq) - CNT_W'(reclaim);

            if (issue_valid && !issue_ready) begin
                held     <= 1'b1;
                held_idx <= offer_idx;
            end else begin
                held <= 1'b0;
            end
        end
    end

endmodule
